// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised 2-read/1-write register file with pending-write scoreboard
module regfile_param #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int INIT_R0  = 2,
  parameter int INIT_R1  = 1,
  parameter int REG_READ = 0,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              busy1,
  output logic              busy2,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                addr_err_q, addr_err_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;

  logic              wr_ok, rsv_ok, rd1_ok, rd2_ok, fwd1, fwd2;
  logic [DATA_W-1:0] raw1, raw2, comb1, comb2;
  logic              bsy1, bsy2;

  assign wr_ok  = {1'b0, write_reg} < NREGS;
  assign rsv_ok = {1'b0, rsv_reg}   < NREGS;
  assign rd1_ok = {1'b0, read_reg1} < NREGS;
  assign rd2_ok = {1'b0, read_reg2} < NREGS;

  // Out-of-range addresses match no entry, so they read as zero and not busy.
  always_comb begin
    raw1 = '0;
    raw2 = '0;
    bsy1 = 1'b0;
    bsy2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_reg1 == ADDR_W'(i)) begin
        raw1 = regs_q[i];
        bsy1 = busy_q[i];
      end
      if (read_reg2 == ADDR_W'(i)) begin
        raw2 = regs_q[i];
        bsy2 = busy_q[i];
      end
    end
  end

  assign fwd1  = (BYPASS != 0) && !rst && we && wr_ok && (write_reg == read_reg1);
  assign fwd2  = (BYPASS != 0) && !rst && we && wr_ok && (write_reg == read_reg2);
  assign comb1 = fwd1 ? write_data : raw1;
  assign comb2 = fwd2 ? write_data : raw2;

  // Clear on write first, then set on reservation, so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && write_reg == ADDR_W'(i)) begin
        regs_d[i] = write_data;
        busy_d[i] = 1'b0;
      end
      if (rsv_en && rsv_reg == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    addr_err_d = addr_err_q | (we & ~wr_ok) | (rsv_en & ~rsv_ok) | ~rd1_ok | ~rd2_ok;
    rdata1_d   = comb1;
    rdata2_d   = comb2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0) begin
          regs_q[i] <= DATA_W'(INIT_R0);
        end else if (i == 1) begin
          regs_q[i] <= DATA_W'(INIT_R1);
        end else begin
          regs_q[i] <= '0;
        end
      end
      busy_q     <= '0;
      addr_err_q <= 1'b0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
    end
  end

  assign read_data1 = (REG_READ != 0) ? rdata1_q : comb1;
  assign read_data2 = (REG_READ != 0) ? rdata2_q : comb2;
  assign busy1      = rd1_ok & bsy1;
  assign busy2      = rd2_ok & bsy2;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed bench for regfile_param in all four read/bypass modes
module tb_regfile_param;
  localparam int DW = 8;
  localparam int NR = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] write_reg = '0, read_reg1 = '0, read_reg2 = '0, rsv_reg = '0;
  logic [DW-1:0] write_data = '0;

  logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2, d_rd1, d_rd2;
  logic          a_b1, a_b2, a_err, b_b1, b_b2, b_err, c_b1, c_b2, c_err, d_b1, d_b2, d_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(DW), .NUM_REGS(NR), .REG_READ(0), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .we(we), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(a_rd1), .read_data2(a_rd2),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(a_b1), .busy2(a_b2), .addr_err(a_err));
  regfile_param #(.DATA_W(DW), .NUM_REGS(NR), .REG_READ(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(b_rd1), .read_data2(b_rd2),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(b_b1), .busy2(b_b2), .addr_err(b_err));
  regfile_param #(.DATA_W(DW), .NUM_REGS(NR), .REG_READ(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .we(we), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(c_rd1), .read_data2(c_rd2),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(c_b1), .busy2(c_b2), .addr_err(c_err));
  regfile_param #(.DATA_W(DW), .NUM_REGS(NR), .REG_READ(1), .BYPASS(0)) u_d (
    .clk(clk), .rst(rst), .we(we), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_data1(d_rd1), .read_data2(d_rd2),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy1(d_b1), .busy2(d_b2), .addr_err(d_err));

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (c_rd1 !== 8'h00) begin bad++; $display("FAIL reset_regread_zero got=%h exp=00", c_rd1); end
    total++; if ({a_err, b_err, c_err, d_err} !== 4'b0000) begin bad++; $display("FAIL reset_addr_err got=%b exp=0000", {a_err, b_err, c_err, d_err}); end
    read_reg1 = 3'd0;
    read_reg2 = 3'd1;
    #1;
    total++; if (a_rd1 !== 8'h02) begin bad++; $display("FAIL reset_r0 got=%h exp=02", a_rd1); end
    total++; if (a_rd2 !== 8'h01) begin bad++; $display("FAIL reset_r1 got=%h exp=01", a_rd2); end
    step();
    total++; if (c_rd1 !== 8'h02) begin bad++; $display("FAIL reset_r0_reg got=%h exp=02", c_rd1); end
    total++; if (c_rd2 !== 8'h01) begin bad++; $display("FAIL reset_r1_reg got=%h exp=01", c_rd2); end
    read_reg1 = 3'd5;
    #1;
    total++; if (a_rd1 !== 8'h00) begin bad++; $display("FAIL reset_r5 got=%h exp=00", a_rd1); end
    total++; if ({a_b1, a_b2} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {a_b1, a_b2}); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err_after got=%b exp=0", a_err); end
  endtask

  task automatic test_bypass();
    we = 1'b1; write_reg = 3'd3; write_data = 8'hA5; read_reg1 = 3'd3;
    #1;
    total++; if (a_rd1 !== 8'hA5) begin bad++; $display("FAIL bypass_on got=%h exp=a5", a_rd1); end
    total++; if (b_rd1 !== 8'h00) begin bad++; $display("FAIL bypass_off got=%h exp=00", b_rd1); end
    step();
    total++; if (c_rd1 !== 8'hA5) begin bad++; $display("FAIL bypass_reg_on got=%h exp=a5", c_rd1); end
    total++; if (d_rd1 !== 8'h00) begin bad++; $display("FAIL bypass_reg_off got=%h exp=00", d_rd1); end
    we = 1'b0;
    #1;
    total++; if (b_rd1 !== 8'hA5) begin bad++; $display("FAIL bypass_off_after got=%h exp=a5", b_rd1); end
    step();
    total++; if (d_rd1 !== 8'hA5) begin bad++; $display("FAIL bypass_reg_off_late got=%h exp=a5", d_rd1); end
  endtask

  task automatic test_scoreboard();
    read_reg1 = 3'd2; read_reg2 = 3'd2; rsv_en = 1'b1; rsv_reg = 3'd2;
    #1;
    total++; if (a_b1 !== 1'b0) begin bad++; $display("FAIL sb_no_bypass got=%b exp=0", a_b1); end
    step();
    rsv_en = 1'b0;
    #1;
    total++; if (a_b1 !== 1'b1) begin bad++; $display("FAIL sb_set got=%b exp=1", a_b1); end
    we = 1'b1; write_reg = 3'd2; write_data = 8'h3C;
    #1;
    total++; if (a_b1 !== 1'b1) begin bad++; $display("FAIL sb_before_clear got=%b exp=1", a_b1); end
    step();
    we = 1'b0;
    #1;
    total++; if (a_b1 !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b exp=0", a_b1); end
    total++; if (a_rd1 !== 8'h3C) begin bad++; $display("FAIL sb_write_data got=%h exp=3c", a_rd1); end
    rsv_en = 1'b1; rsv_reg = 3'd2; we = 1'b1; write_reg = 3'd2; write_data = 8'h5A;
    step();
    rsv_en = 1'b0; we = 1'b0;
    #1;
    total++; if ({a_b1, a_b2} !== 2'b11) begin bad++; $display("FAIL sb_set_wins got=%b exp=11", {a_b1, a_b2}); end
    total++; if (a_rd1 !== 8'h5A) begin bad++; $display("FAIL sb_set_wins_data got=%h exp=5a", a_rd1); end
    total++; if (a_rd2 !== 8'h5A) begin bad++; $display("FAIL sb_port2_same got=%h exp=5a", a_rd2); end
    rsv_en = 1'b1; rsv_reg = 3'd2;
    step();
    rsv_en = 1'b0;
    #1;
    total++; if (a_b1 !== 1'b1) begin bad++; $display("FAIL sb_rereserve got=%b exp=1", a_b1); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL sb_rereserve_err got=%b exp=0", a_err); end
  endtask

  task automatic test_range();
    logic [DW-1:0] exp_r [NR] = '{8'h02, 8'h01, 8'h5A, 8'hA5, 8'h00, 8'h00};
    read_reg1 = 3'd0; read_reg2 = 3'd0;
    we = 1'b1; write_reg = 3'd7; write_data = 8'hFF;
    #1;
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL range_err_before got=%b exp=0", a_err); end
    step();
    we = 1'b0;
    #1;
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL range_err_set got=%b exp=1", a_err); end
    for (int i = 0; i < NR; i++) begin
      read_reg1 = AW'(i);
      #1;
      total++; if (a_rd1 !== exp_r[i]) begin bad++; $display("FAIL range_unchanged_r%0d got=%h exp=%h", i, a_rd1, exp_r[i]); end
    end
    read_reg1 = 3'd0;
    read_reg2 = 3'd6;
    #1;
    total++; if (a_rd2 !== 8'h00) begin bad++; $display("FAIL range_read6 got=%h exp=00", a_rd2); end
    total++; if (a_b2 !== 1'b0) begin bad++; $display("FAIL range_busy6 got=%b exp=0", a_b2); end
    step();
    total++; if (c_rd2 !== 8'h00) begin bad++; $display("FAIL range_read6_reg got=%h exp=00", c_rd2); end
    read_reg2 = 3'd0;
    step();
    step();
    total++; if ({a_err, c_err} !== 2'b11) begin bad++; $display("FAIL range_sticky got=%b exp=11", {a_err, c_err}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL range_err_cleared got=%b exp=0", a_err); end
    rsv_en = 1'b1; rsv_reg = 3'd7;
    step();
    rsv_en = 1'b0;
    #1;
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL range_rsv_err got=%b exp=1", a_err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reg_read();
    read_reg2 = 3'd1; we = 1'b1; write_reg = 3'd1; write_data = 8'h77;
    step();
    we = 1'b0;
    #1;
    total++; if (c_rd2 !== 8'h77) begin bad++; $display("FAIL regread_bypass got=%h exp=77", c_rd2); end
    total++; if (d_rd2 !== 8'h01) begin bad++; $display("FAIL regread_nobypass_old got=%h exp=01", d_rd2); end
    step();
    total++; if (d_rd2 !== 8'h77) begin bad++; $display("FAIL regread_nobypass_new got=%h exp=77", d_rd2); end
  endtask

  task automatic test_reset_priority();
    rsv_en = 1'b1; rsv_reg = 3'd4; we = 1'b1; write_reg = 3'd4; write_data = 8'h11;
    step();
    rsv_en = 1'b0; we = 1'b0; read_reg1 = 3'd4;
    #1;
    total++; if (a_rd1 !== 8'h11) begin bad++; $display("FAIL prio_setup_data got=%h exp=11", a_rd1); end
    total++; if (a_b1 !== 1'b1) begin bad++; $display("FAIL prio_setup_busy got=%b exp=1", a_b1); end
    rst = 1'b1; we = 1'b1; write_reg = 3'd4; write_data = 8'h99; rsv_en = 1'b1; rsv_reg = 3'd4;
    step();
    rst = 1'b0; we = 1'b0; rsv_en = 1'b0; read_reg2 = 3'd0;
    #1;
    total++; if (a_rd1 !== 8'h00) begin bad++; $display("FAIL prio_r4 got=%h exp=00", a_rd1); end
    total++; if (a_b1 !== 1'b0) begin bad++; $display("FAIL prio_busy got=%b exp=0", a_b1); end
    total++; if (a_rd2 !== 8'h02) begin bad++; $display("FAIL prio_r0 got=%h exp=02", a_rd2); end
    total++; if (c_rd1 !== 8'h00) begin bad++; $display("FAIL prio_regread_zero got=%h exp=00", c_rd1); end
    step();
    total++; if (c_rd2 !== 8'h02) begin bad++; $display("FAIL prio_regread_r0 got=%h exp=02", c_rd2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_bypass();
    test_scoreboard();
    test_range();
    test_reg_read();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning the width of each register in bits (allowed range 1..32).
REQ-002 The block SHALL have parameter NUM_REGS, default 4, meaning the number of registers (allowed range 2..32, not necessarily a power of 2).
REQ-003 The block SHALL have parameter INIT_R0, default 2, meaning the reset value of R0.
REQ-004 The block SHALL have parameter INIT_R1, default 1, meaning the reset value of R1.
REQ-005 The block SHALL have parameter REG_READ, default 0, meaning read mode: 0 selects combinational read, 1 selects registered read with 1-cycle latency.
REQ-006 The block SHALL have parameter BYPASS, default 1, meaning that 1 enables write-to-read forwarding in the same cycle.
REQ-007 The block SHALL derive localparam ADDR_W = max(1, clog2(NUM_REGS)).
REQ-008 The block SHALL have port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port rst: input, 1 bit, reset, synchronous and active-high.
REQ-010 The block SHALL have port we: input, 1 bit, write enable.
REQ-011 The block SHALL have port write_reg: input, ADDR_W bits, write address.
REQ-012 The block SHALL have port write_data: input, DATA_W bits, write data.
REQ-013 The block SHALL have ports read_reg1 and read_reg2: input, ADDR_W bits each, read addresses for ports 1 and 2.
REQ-014 The block SHALL have ports read_data1 and read_data2: output, DATA_W bits each, read data for ports 1 and 2.
REQ-015 The block SHALL have port rsv_en: input, 1 bit, which reserves a register as pending-write (scoreboard set).
REQ-016 The block SHALL have port rsv_reg: input, ADDR_W bits, the register to reserve.
REQ-017 The block SHALL have ports busy1 and busy2: output, 1 bit each, the pending-write flag of read_reg1 and read_reg2 respectively.
REQ-018 The block SHALL have port addr_err: output, 1 bit, a registered sticky flag for any out-of-range access.

Function
REQ-019 Storage SHALL be NUM_REGS x DATA_W; INIT_R0 and INIT_R1 SHALL be truncated to DATA_W.
REQ-020 A write SHALL occur at a clk edge when we=1, rst=0 and write_reg<NUM_REGS: registers[write_reg] <= write_data.
REQ-021 A write with write_reg>=NUM_REGS SHALL be dropped and SHALL set addr_err at that edge.
REQ-022 When REG_READ=0, read_dataN SHALL equal registers[read_regN] combinationally.
REQ-023 When REG_READ=0 and BYPASS=1, read_dataN SHALL equal write_data whenever we=1 and write_reg==read_regN (in range).
REQ-024 When REG_READ=1, read_dataN SHALL be registered: the value at edge k+1 SHALL reflect the address at edge k, including any write at edge k when BYPASS=1; with BYPASS=0 it SHALL reflect the old value.
REQ-025 A read of address >=NUM_REGS SHALL return 0 and SHALL set addr_err (at the next edge in both modes).
REQ-026 Scoreboard: busy[r] SHALL be set at the edge where rsv_en=1 and rsv_reg=r, and SHALL be cleared at the edge where we=1 and write_reg=r.
REQ-027 When rsv_en and we target the same register in the same cycle, set SHALL win (busy stays 1, data is still written).
REQ-028 A reservation of an already-busy register SHALL leave busy=1 with no error; an out-of-range rsv_reg SHALL be ignored and SHALL set addr_err.
REQ-029 busyN SHALL be combinational from busy[read_regN], SHALL be 0 for out-of-range addresses, and SHALL NOT be bypassed by a same-cycle rsv_en.
REQ-030 addr_err SHALL be sticky until rst.
REQ-031 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.

Reset
REQ-032 At a clk edge with rst=1: R0<=INIT_R0, R1<=INIT_R1, all other registers <=0, all busy <=0, addr_err<=0, and registered read_data <=0 when REG_READ=1.
REQ-033 rst SHALL take priority over we and rsv_en in the same cycle; writes and reservations presented during rst SHALL be discarded.
REQ-034 Reset mid-operation SHALL abandon pending reservations; read ports SHALL show reset contents starting from the first post-reset cycle.

Verification (DATA_W=8, NUM_REGS=6, defaults otherwise)
REQ-035 Reset test: pulse rst, then read R0/R1/R5 -> read_data = 0x02, 0x01, 0x00; busy1=busy2=0; addr_err=0.
REQ-036 Bypass test: we=1, write_reg=3, write_data=0xA5, read_reg1=3 in the same cycle -> read_data1=0xA5 before the edge (BYPASS=1) and 0x00 before the edge (BYPASS=0).
REQ-037 Scoreboard test: rsv_en on R2 -> busy1=1 from the next cycle with read_reg1=2; write R2=0x3C -> busy1=0 after the edge; simultaneous rsv_en+we on R2 -> busy stays 1 and data=new value.
REQ-038 Range test: write to address 7 with data 0xFF -> no register changes, addr_err=1 after the edge; read of address 6 -> 0x00; addr_err stays 1 until rst.
REQ-039 REG_READ=1 test: read_reg2=1 with a write of R1=0x77 at edge k -> read_data2=0x77 after edge k (BYPASS=1), or 0x01 after edge k then 0x77 after edge k+1 (BYPASS=0).
REQ-040 Reset-priority test: rst=1 together with we=1 (R4=0x99) and rsv_en (R4) -> R4=0x00 and busy[4]=0 after the edge.
